// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared state encoding, default timing and helpers for the
//                alarm siren controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        SOUND   = 2'd2,
        HOLDOFF = 2'd3
    } siren_state_e;

    localparam int DEF_ENTRY_CYCLES   = 16;
    localparam int DEF_ON_CYCLES      = 4;
    localparam int DEF_OFF_CYCLES     = 4;
    localparam int DEF_SOUND_CYCLES   = 64;
    localparam int DEF_HOLDOFF_CYCLES = 8;
    localparam int DEF_CNT_W          = 8;
    localparam int EVENT_CNT_W        = 8;

    // Down-counters run from N-1 to 0 so a phase lasts exactly N cycles.
    function automatic int load_of(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_cadence_gen.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_cadence_gen
//  Description : ON/OFF cadence generator for the siren; starts high on
//                restart and idles low whenever not enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_cadence_gen
    import alarm_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic enable_i,
    output logic siren_raw_o
);

    localparam logic [CNT_W-1:0] C_ON_LOAD  = CNT_W'(load_of(ON_CYCLES));
    localparam logic [CNT_W-1:0] C_OFF_LOAD = CNT_W'(load_of(OFF_CYCLES));

    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (restart_i) begin
            phase_d = 1'b1;
            cnt_d   = C_ON_LOAD;
        end else if (enable_i) begin
            if (cnt_q == '0) begin
                phase_d = ~phase_q;
                cnt_d   = phase_q ? C_OFF_LOAD : C_ON_LOAD;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            phase_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign siren_raw_o = phase_q;

endmodule
`default_nettype wire

// File: rtl/alarm_siren_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_siren_ctrl
//  Description : Turns an alarm trigger into entry delay, cadenced siren with
//                auto-timeout, and post-alarm holdoff.
//                Optional macro ALARM_SIREN_EVENT_CNT_EN enables event_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_siren_ctrl
    import alarm_pkg::*;
#(
    parameter int ENTRY_CYCLES   = DEF_ENTRY_CYCLES,
    parameter int ON_CYCLES      = DEF_ON_CYCLES,
    parameter int OFF_CYCLES     = DEF_OFF_CYCLES,
    parameter int SOUND_CYCLES   = DEF_SOUND_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   armed,
    input  logic                   triggered,
    input  logic                   disarmed,
    input  logic                   silence,
    output logic                   siren,
    output logic                   strobe,
    output logic                   timed_out,
    output logic [1:0]             state_o,
    output logic [EVENT_CNT_W-1:0] event_count
);

    localparam logic [CNT_W-1:0] C_ENTRY_LOAD   = CNT_W'(load_of(ENTRY_CYCLES));
    localparam logic [CNT_W-1:0] C_SOUND_LOAD   = CNT_W'(load_of(SOUND_CYCLES));
    localparam logic [CNT_W-1:0] C_HOLDOFF_LOAD = CNT_W'(load_of(HOLDOFF_CYCLES));

    siren_state_e     state_q;
    logic [CNT_W-1:0] timer_q;
    logic             strobe_q;
    logic             timed_out_q;

    logic w_timer_zero;
    logic w_sound_entry;
    logic w_sound_stay;
    logic w_siren_raw;
    logic w_unused_armed;

    // armed is status only; nothing here depends on it.
    assign w_unused_armed = armed;

    assign w_timer_zero  = (timer_q == '0);
    assign w_sound_entry = (state_q == ENTRY) && !disarmed && w_timer_zero;
    assign w_sound_stay  = (state_q == SOUND) && !disarmed && !silence && !w_timer_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            strobe_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            if (disarmed) begin
                timed_out_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!disarmed && triggered) begin
                        state_q <= ENTRY;
                        timer_q <= C_ENTRY_LOAD;
                    end
                end
                ENTRY: begin
                    if (disarmed) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (w_timer_zero) begin
                        state_q  <= SOUND;
                        timer_q  <= C_SOUND_LOAD;
                        strobe_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                SOUND: begin
                    if (disarmed || silence || w_timer_zero) begin
                        state_q  <= HOLDOFF;
                        timer_q  <= C_HOLDOFF_LOAD;
                        strobe_q <= 1'b0;
                        // Only a genuine expiry marks the timeout; user actions outrank it.
                        if (!disarmed && !silence) begin
                            timed_out_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (disarmed || w_timer_zero) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    alarm_cadence_gen #(
        .ON_CYCLES  (ON_CYCLES),
        .OFF_CYCLES (OFF_CYCLES),
        .CNT_W      (CNT_W)
    ) u_cadence (
        .clk_i       (clk),
        .rst_i       (reset),
        .restart_i   (w_sound_entry),
        .enable_i    (w_sound_stay),
        .siren_raw_o (w_siren_raw)
    );

`ifdef ALARM_SIREN_EVENT_CNT_EN
    logic [EVENT_CNT_W-1:0] event_cnt_q, event_cnt_d;

    always_comb begin
        event_cnt_d = event_cnt_q;
        if (w_sound_entry && (event_cnt_q != '1)) begin
            event_cnt_d = event_cnt_q + EVENT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_cnt_q <= '0;
        end else begin
            event_cnt_q <= event_cnt_d;
        end
    end

    assign event_count = event_cnt_q;
`else
    assign event_count = '0;
`endif

    assign siren     = w_siren_raw;
    assign strobe    = strobe_q;
    assign timed_out = timed_out_q;
    assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_siren_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_siren_ctrl
//  Description : Directed and randomized bench for alarm_siren_ctrl against a
//                dwell-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_siren_ctrl;

    localparam int ENTRY_N = 4;
    localparam int ON_N    = 4;
    localparam int OFF_N   = 4;
    localparam int SOUND_N = 64;
    localparam int HOLD_N  = 8;
`ifdef ALARM_SIREN_EVENT_CNT_EN
    localparam int EVT_EN  = 1;
`else
    localparam int EVT_EN  = 0;
`endif

    logic       clk, reset, armed, triggered, disarmed, silence;
    logic       siren, strobe, timed_out;
    logic [1:0] state_o;
    logic [7:0] event_count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: current mode (0..3), cycles spent in it, sticky flag, event tally.
    int m_mode, m_age, m_evt;
    bit m_to;

    alarm_siren_ctrl #(
        .ENTRY_CYCLES   (ENTRY_N),
        .ON_CYCLES      (ON_N),
        .OFF_CYCLES     (OFF_N),
        .SOUND_CYCLES   (SOUND_N),
        .HOLDOFF_CYCLES (HOLD_N),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .armed       (armed),
        .triggered   (triggered),
        .disarmed    (disarmed),
        .silence     (silence),
        .siren       (siren),
        .strobe      (strobe),
        .timed_out   (timed_out),
        .state_o     (state_o),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dwell(input int mode);
        case (mode)
            1:       return ENTRY_N;
            2:       return SOUND_N;
            3:       return HOLD_N;
            default: return 1 << 30;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_age  = 0;
        m_evt  = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_edge();
        int nxt;
        bit done;
        nxt  = m_mode;
        done = (m_age + 1 >= dwell(m_mode));
        if (disarmed) m_to = 1'b0;
        case (m_mode)
            0: if (!disarmed && triggered) nxt = 1;
            1: begin
                if (disarmed) nxt = 0;
                else if (done) begin
                    nxt   = 2;
                    m_evt = (m_evt < 255) ? m_evt + 1 : 255;
                end
            end
            2: begin
                if (disarmed || silence) nxt = 3;
                else if (done) begin
                    nxt  = 3;
                    m_to = 1'b1;
                end
            end
            default: if (disarmed || done) nxt = 0;
        endcase
        m_age  = (nxt != m_mode) ? 0 : m_age + 1;
        m_mode = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic check_all();
        chk("state",     {30'd0, state_o}, m_mode);
        chk("siren",     {31'd0, siren},
            {31'd0, (m_mode == 2) && ((m_age % (ON_N + OFF_N)) < ON_N)});
        chk("strobe",    {31'd0, strobe}, {31'd0, m_mode == 2});
        chk("timed_out", {31'd0, timed_out}, {31'd0, m_to});
        chk("event_count", {24'd0, event_count}, EVT_EN ? m_evt : 0);
    endtask

    task automatic cyc(input logic t, input logic d, input logic s);
        triggered = t;
        disarmed  = d;
        silence   = s;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_sound();
        cyc(1'b1, 1'b0, 1'b0);
        run(ENTRY_N);
    endtask

    initial begin
        int saved_evt;
        reset = 1'b1; armed = 1'b0; triggered = 1'b0; disarmed = 1'b0; silence = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b0;
        armed = 1'b1;
        run(3);

        // Full sounding to timeout, cadence, sticky timed_out
        cyc(1'b1, 1'b0, 1'b0);
        chk("entry_state", {30'd0, state_o}, 32'd1);
        run(ENTRY_N - 1);
        chk("entry_hold", {30'd0, state_o}, 32'd1);
        run(1);
        chk("sound_siren", {31'd0, siren}, 32'd1);
        chk("sound_strobe", {31'd0, strobe}, 32'd1);
        for (int i = 1; i < SOUND_N; i++) begin
            run(1);
            if (i < 8) chk("cadence", {31'd0, siren}, {31'd0, i < 4});
        end
        chk("pre_timeout", {30'd0, state_o}, 32'd2);
        run(1);
        chk("timeout_state", {30'd0, state_o}, 32'd3);
        chk("timeout_flag", {31'd0, timed_out}, 32'd1);
        run(HOLD_N);
        chk("holdoff_done", {30'd0, state_o}, 32'd0);
        chk("sticky_flag", {31'd0, timed_out}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("disarm_clear", {31'd0, timed_out}, 32'd0);

        // Abort during entry
        saved_evt = m_evt;
        cyc(1'b1, 1'b0, 1'b0);
        run(1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("entry_abort", {30'd0, state_o}, 32'd0);
        run(6);
        chk("abort_evt", {24'd0, event_count}, EVT_EN ? saved_evt : 0);

        // Silence, holdoff ignores trigger
        start_sound();
        run(5);
        cyc(1'b0, 1'b0, 1'b1);
        chk("silence_state", {30'd0, state_o}, 32'd3);
        chk("silence_siren", {31'd0, siren}, 32'd0);
        run(2);
        cyc(1'b1, 1'b0, 1'b0);
        chk("holdoff_ignore", {30'd0, state_o}, 32'd3);
        run(4);
        run(1);
        chk("holdoff_exit", {30'd0, state_o}, 32'd0);

        // Re-trigger held through holdoff
        start_sound();
        cyc(1'b1, 1'b0, 1'b1);
        repeat (HOLD_N) cyc(1'b1, 1'b0, 1'b0);
        chk("retrig_idle", {30'd0, state_o}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("retrig_entry", {30'd0, state_o}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0);

        // disarmed and silence together while timed_out is set
        start_sound();
        run(SOUND_N);
        run(HOLD_N);
        start_sound();
        chk("sticky_resound", {31'd0, timed_out}, 32'd1);
        run(3);
        cyc(1'b0, 1'b1, 1'b1);
        chk("dis_sil_state", {30'd0, state_o}, 32'd3);
        chk("dis_sil_flag", {31'd0, timed_out}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("holdoff_disarm", {30'd0, state_o}, 32'd0);

        // Asynchronous reset mid-SOUND with timed_out set
        start_sound();
        run(SOUND_N);
        run(HOLD_N);
        start_sound();
        run(5);
        #2 reset = 1'b1;
        #1;
        chk("arst_siren", {31'd0, siren}, 32'd0);
        chk("arst_strobe", {31'd0, strobe}, 32'd0);
        chk("arst_flag", {31'd0, timed_out}, 32'd0);
        chk("arst_state", {30'd0, state_o}, 32'd0);
        model_reset();
        check_all();
        #2 reset = 1'b0;

        // Three soundings after reset
        repeat (3) begin
            start_sound();
            cyc(1'b0, 1'b0, 1'b1);
            run(HOLD_N);
        end
        chk("evt_three", {24'd0, event_count}, EVT_EN ? 32'd3 : 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            armed = 1'($urandom);
            cyc(1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_siren_ctrl.md
Name: alarm_siren_ctrl

Overview:
Downstream consumer of the alarm controller's status outputs (disarmed, armed, triggered). Converts a trigger event into an entry-delay grace window, then a cadenced siren drive with auto-timeout and a post-alarm holdoff. Sits between the alarm FSM and the siren/strobe driver pads. All outputs are registered so the bench monitor can sample them cleanly.

Parameters:
ENTRY_CYCLES, 16, grace cycles between trigger and siren start (>=1)
ON_CYCLES, 4, siren-high cycles per cadence period (>=1)
OFF_CYCLES, 4, siren-low cycles per cadence period (>=1)
SOUND_CYCLES, 64, maximum sounding duration before auto-timeout (>=1)
HOLDOFF_CYCLES, 8, cycles after sounding during which triggered is ignored (>=1)
CNT_W, 8, width of all internal timers; must hold the max of the above

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
armed  input  1  alarm FSM armed status
triggered  input  1  alarm FSM triggered status
disarmed  input  1  alarm FSM disarmed status; aborts entry/sounding
silence  input  1  user acknowledge; stops sounding
siren  output  1  cadenced siren drive
strobe  output  1  steady high throughout SOUND
timed_out  output  1  sticky flag: sounding ended by timeout
state_o  output  2  current state encoding, for monitor
event_count  output  8  count of SOUND entries (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset (async, any state): state=IDLE; siren=0, strobe=0, timed_out=0, event_count=0, all timers 0.
- States (state_o): IDLE=0, ENTRY=1, SOUND=2, HOLDOFF=3.
- IDLE: triggered=1 at edge N -> ENTRY, timer=ENTRY_CYCLES-1. armed is informational only.
- ENTRY: disarmed=1 -> IDLE, no siren ever. Otherwise timer decrements. At timer==0 -> SOUND at edge N+ENTRY_CYCLES; siren=1 and strobe=1 after that edge.
- SOUND: cadence counter gives siren=1 for ON_CYCLES, 0 for OFF_CYCLES, repeating, starting high. Sound timer counts SOUND_CYCLES. Exits to HOLDOFF, siren=0 and strobe=0 after the exiting edge, on:
  - disarmed=1: also clears timed_out.
  - silence=1.
  - sound timer expiry: sets timed_out=1.
- HOLDOFF: triggered ignored; timer HOLDOFF_CYCLES-1 down to 0, then -> IDLE. disarmed=1 -> IDLE immediately.
- timed_out: sticky. Clears only on disarmed=1 (any state) or reset.
- Priority for simultaneous events: reset > disarmed > silence > timeout > triggered. silence in IDLE/ENTRY/HOLDOFF has no effect.
- Re-trigger: triggered held high through HOLDOFF -> IDLE then ENTRY on the next edge.
- Timers saturate at 0; no wrap-around.

Optional Feature:
ALARM_SIREN_EVENT_CNT_EN
- Defined: event_count increments on each ENTRY->SOUND transition, saturates at 255, and clears only on reset.
- Undefined: event_count tied to 0, and the counter logic is absent.

Decomposition:
- Package alarm_pkg:
  - siren_state_e enum (IDLE, ENTRY, SOUND, HOLDOFF; 2-bit).
  - Default timing constants.
  - EVENT_CNT_W=8.
- One natural sub-module: alarm_cadence_gen. Counts ON/OFF phases and outputs siren_raw. Enabled only in SOUND and restarted at SOUND entry.

Test Plan (ENTRY=4, ON=4, OFF=4, SOUND=64, HOLDOFF=8):
- triggered=1 at edge 10 -> state_o=1 after edge 10; siren=1, strobe=1 after edge 14; siren pattern 1111 0000 repeating.
- triggered at edge 10, disarmed=1 at edge 12 -> state_o=0 after edge 12; siren stays 0; event_count unchanged.
- Sounding from edge 14, silence=1 at edge 20 -> siren=0 after edge 20; state_o=3 for 8 cycles; triggered pulse at edge 23 ignored; IDLE after edge 28.
- No intervention after siren start at edge 14 -> HOLDOFF after edge 78; timed_out=1; timed_out stays 1 until disarmed=1, then 0.
- reset=1 asynchronously mid-SOUND -> siren, strobe, timed_out, state_o all 0 immediately, without waiting for a clock edge.
- disarmed=1 and silence=1 on the same edge in SOUND -> HOLDOFF entered and timed_out cleared (disarmed wins). With ALARM_SIREN_EVENT_CNT_EN, 3 soundings -> event_count=3.
